// File: rtl/csa_resolve_serial.sv
// Chunk-serial carry-propagate adder for carry-save pairs: sum_o = c_i + s_i, valid NCHUNK edges after accept.
// Holds the result in DONE indefinitely while out_ready_i=0; accepts new pairs only in IDLE.
module csa_resolve_serial #(
   parameter int OP_WIDTH    = 32,
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [OP_WIDTH:0]   c_i,
   input  logic [OP_WIDTH:0]   s_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [OP_WIDTH+1:0] sum_o
);
   localparam int W      = OP_WIDTH + 1;
   localparam int NCHUNK = (W + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
   localparam int PW     = NCHUNK * CHUNK_WIDTH;
   localparam int CNT_W  = $clog2(NCHUNK + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state_q, state_d;
   logic [PW-1:0]             c_q, s_q, res_q;
   logic                      carry_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [CHUNK_WIDTH:0]      chunk_sum;
   logic [PW+CHUNK_WIDTH-1:0] res_sh;
   logic [PW:0]               full;
   logic                      last;

   // Operands shift right so the active chunk is always at bit 0; results enter from the top.
   assign chunk_sum = {1'b0, c_q[CHUNK_WIDTH-1:0]} + {1'b0, s_q[CHUNK_WIDTH-1:0]}
                    + (CHUNK_WIDTH+1)'(carry_q);
   assign res_sh    = {chunk_sum[CHUNK_WIDTH-1:0], res_q};
   assign last      = (cnt_q == LAST);

   assign full        = {carry_q, res_q};
   assign sum_o       = full[OP_WIDTH+1:0];
   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);

   generate
      if (PW > W) begin : g_pad
         logic unused_pad;
         assign unused_pad = ^full[PW:OP_WIDTH+2];
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid_i)  state_d = RUN;
         RUN:     if (last)        state_d = DONE;
         DONE:    if (out_ready_i) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         c_q     <= '0;
         s_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  c_q     <= PW'(c_i);
                  s_q     <= PW'(s_i);
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               c_q     <= c_q >> CHUNK_WIDTH;
               s_q     <= s_q >> CHUNK_WIDTH;
               res_q   <= res_sh[PW+CHUNK_WIDTH-1:CHUNK_WIDTH];
               carry_q <= chunk_sum[CHUNK_WIDTH];
               cnt_q   <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_csa_resolve_serial.sv
// Bench for csa_resolve_serial: directed vectors, back-pressure, reset mid-run, degenerate chunking, random stalls.
module tb_csa_resolve_serial;
   localparam int NCH    = 5;
   localparam int TRIALS = 2000;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [32:0] c = '0, s = '0;
   logic [33:0] sum;

   logic        in_valid2 = 1'b0;
   logic        in_ready2, out_valid2;
   logic [32:0] c2 = '0, s2 = '0;
   logic [33:0] sum2;

   int          vectors = 0, errors = 0;
   int          cyc = 0, n_pop = 0;
   logic        prev_valid = 1'b0;
   logic        rnd_done = 1'b0;
   logic [33:0] exp_q[$];
   int          acc_q[$];

   csa_resolve_serial #(.OP_WIDTH(32), .CHUNK_WIDTH(8)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .c_i(c), .s_i(s), .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum));

   csa_resolve_serial #(.OP_WIDTH(32), .CHUNK_WIDTH(33)) dut_wide (
      .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
      .c_i(c2), .s_i(s2), .out_valid_o(out_valid2), .out_ready_i(1'b1), .sum_o(sum2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // Reference model: every accepted pair must come back once, in order, as c+s, NCH edges later.
   always @(negedge clk) begin
      if (!rst_ni) begin
         exp_q.delete();
         acc_q.delete();
         check("reset_outputs", {sum, out_valid, in_ready}, {34'h0, 1'b0, 1'b1});
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (acc_q.size() == 0) check("spurious_valid", 1, 0);
            else check("latency", 64'(cyc - acc_q.pop_front()), NCH);
         end
         if (out_valid) begin
            check("ready_in_done", 64'(in_ready), 0);
            if (exp_q.size() == 0) check("duplicate_result", 1, 0);
            else check("sum", 64'(sum), 64'(exp_q[0]));
            if (out_ready) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               n_pop++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(34'(c) + 34'(s));
            acc_q.push_back(cyc + 1);
         end
         prev_valid = out_valid;
      end
   end

   // All tasks below start and end 1 time unit after a rising edge.
   task automatic send(input logic [32:0] cc, input logic [32:0] ss);
      int t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) check("send_timeout", 1, 0);
      c = cc; s = ss; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      if (lat >= 200) check("valid_timeout", 1, 0);
   endtask

   task automatic run_one(input string name, input logic [32:0] cc, input logic [32:0] ss,
                          input logic [33:0] want);
      int lat;
      out_ready = 1'b1;
      send(cc, ss);
      wait_valid(lat);
      check(name, 64'(sum), 64'(want));
      check({name, "_lat"}, 64'(lat), NCH);
      @(posedge clk); #1;
   endtask

   task automatic run_wide(input string name, input logic [32:0] cc, input logic [32:0] ss,
                           input logic [33:0] want);
      int lat = 0;
      c2 = cc; s2 = ss; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      while (!out_valid2 && lat < 50) begin @(posedge clk); #1; lat++; end
      check(name, 64'(sum2), 64'(want));
      check({name, "_lat"}, 64'(lat), 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #3;
      check("reset_in_ready", 64'(in_ready), 1);
      check("reset_out_valid", 64'(out_valid), 0);
      check("reset_wide", {sum2, out_valid2, in_ready2}, {34'h0, 1'b0, 1'b1});
      @(posedge clk); @(posedge clk); #1;
      rst_ni = 1'b1;
      @(posedge clk); #1;

      run_one("ripple",  33'h0_0000_0001, 33'h0_FFFF_FFFF, 34'h1_0000_0000);
      run_one("max",     33'h1_FFFF_FFFE, 33'h1_FFFF_FFFF, 34'h3_FFFF_FFFD);
      run_one("zero",    33'h0,           33'h0,           34'h0);
      run_one("mixed",   33'h1_2345_6789, 33'h0_8765_4321, 34'h1_AAAA_AAAA);
      run_one("lsb_c",   33'h1_0000_0001, 33'h1_0000_0001, 34'h2_0000_0002);

      begin : backpressure
         logic [33:0] held;
         int lat;
         out_ready = 1'b0;
         send(33'h1_2345_6789, 33'h0_8765_4321);
         wait_valid(lat);
         held = sum;
         check("bp_sum", 64'(held), 34'h1_AAAA_AAAA);
         for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            c = 33'h0_1111_1111; s = 33'h0_2222_2222;
            @(posedge clk); #1;
            check("bp_hold_sum", 64'(sum), 64'(held));
            check("bp_hold_valid", 64'(out_valid), 1);
            check("bp_in_ready", 64'(in_ready), 0);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         check("bp_release_ready", 64'(in_ready), 1);
         check("bp_release_valid", 64'(out_valid), 0);
         repeat (8) begin @(posedge clk); #1; end
         check("bp_not_captured", 64'(out_valid), 0);
      end

      begin : reset_mid_run
         out_ready = 1'b1;
         send(33'h0_0000_8080, 33'h0_0000_8080);
         @(posedge clk); @(posedge clk); #2;
         rst_ni = 1'b0;
         #1;
         check("rst_run_in_ready", 64'(in_ready), 1);
         check("rst_run_out_valid", 64'(out_valid), 0);
         check("rst_run_sum", 64'(sum), 0);
         @(negedge clk); @(posedge clk); #1;
         rst_ni = 1'b1;
         @(posedge clk); #1;
         run_one("after_reset", 33'h5, 33'h3, 34'h8);
      end

      run_wide("wide_top",   33'h1_0000_0000, 33'h1_0000_0000, 34'h2_0000_0000);
      run_wide("wide_mixed", 33'h1_2345_6789, 33'h0_8765_4321, 34'h1_AAAA_AAAA);
      run_wide("wide_max",   33'h1_FFFF_FFFE, 33'h1_FFFF_FFFF, 34'h3_FFFF_FFFD);

      begin : random_phase
         int pop0;
         int t;
         pop0 = n_pop;
         fork
            begin
               for (int i = 0; i < TRIALS; i++) begin
                  logic [31:0] a, b, d;
                  a = $urandom; b = $urandom; d = $urandom;
                  if (i % 16 == 0) begin a = '1; b = '1; d = '1; end
                  repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                  send({(a & b) | (a & d) | (b & d), 1'b0}, {1'b0, a ^ b ^ d});
               end
               rnd_done = 1'b1;
            end
            begin
               while (!rnd_done) begin
                  out_ready = ($urandom_range(0, 3) != 0);
                  @(posedge clk); #1;
               end
               out_ready = 1'b1;
            end
         join
         t = 0;
         while (exp_q.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
         check("rnd_drain", 64'(exp_q.size()), 0);
         check("rnd_count", 64'(n_pop - pop0), TRIALS);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
